// File: rtl/audio_sd_dac.sv
// Audio output stage: sample hold, soft mute/start gain ramp, one-pole smoothing
// and a second-order 1-bit delta-sigma modulator driving the audio pad.
module audio_sd_dac #(
  parameter int SAMPLE_W     = 8,
  parameter int RAMP_SHIFT   = 6,
  parameter int SMOOTH_SHIFT = 4,
  parameter int INT_W        = SAMPLE_W + 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic                mute,
  output logic                pwm_out,
  output logic                ramp_done
);
  localparam int                      GAIN_W = 9;
  localparam logic [GAIN_W-1:0]       UNITY  = 9'd256;
  localparam int                      FILT_W = SAMPLE_W + SMOOTH_SHIFT;
  localparam int                      SUM_W  = INT_W + 2;
  localparam int                      HALF   = 1 << (SAMPLE_W - 1);
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((1 << (INT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_LO = -SUM_W'(1 << (INT_W - 1));

  logic [SAMPLE_W-1:0]     held_q;
  logic [GAIN_W-1:0]       gain_q;
  logic [RAMP_SHIFT-1:0]   ramp_ctr_q;
  logic [SAMPLE_W-1:0]     scaled_q;
  logic [FILT_W-1:0]       filt_q;
  logic signed [INT_W-1:0] i1_q, i2_q;
  logic                    q_q;

  logic [SAMPLE_W+GAIN_W-1:0] prod;
  logic [SAMPLE_W:0]          scaled_w;
  logic [SAMPLE_W-1:0]        scaled_d;
  logic [FILT_W:0]            filt_sum;
  logic [FILT_W-1:0]          filt_d;
  logic [SAMPLE_W-1:0]        x;
  logic signed [SUM_W-1:0]    xc, fb, s1, s2;
  logic signed [INT_W-1:0]    i1n, i2n;
  logic                       wrap;

  function automatic logic signed [INT_W-1:0] sat(input logic signed [SUM_W-1:0] v);
    if (v > SAT_HI)      sat = SAT_HI[INT_W-1:0];
    else if (v < SAT_LO) sat = SAT_LO[INT_W-1:0];
    else                 sat = v[INT_W-1:0];
  endfunction

  // gain=256 with >>8 reproduces held exactly; the clamp only guards the 9th bit
  assign prod     = {{GAIN_W{1'b0}}, held_q} * {{SAMPLE_W{1'b0}}, gain_q};
  assign scaled_w = prod[SAMPLE_W+8:8];
  assign scaled_d = scaled_w[SAMPLE_W] ? {SAMPLE_W{1'b1}} : scaled_w[SAMPLE_W-1:0];

  // filt settles at scaled<<SMOOTH_SHIFT, so it stays inside FILT_W bits
  assign filt_sum = {1'b0, filt_q} + {{(FILT_W+1-SAMPLE_W){1'b0}}, scaled_q}
                  - {1'b0, (filt_q >> SMOOTH_SHIFT)};
  assign filt_d   = filt_sum[FILT_W-1:0];
  assign x        = filt_q[FILT_W-1:SMOOTH_SHIFT];

  assign xc  = $signed({{(SUM_W-SAMPLE_W){1'b0}}, x}) - SUM_W'(HALF);
  assign fb  = q_q ? SUM_W'(HALF) : -SUM_W'(HALF);
  assign s1  = SUM_W'(i1_q) + xc - fb;
  assign i1n = sat(s1);
  assign s2  = SUM_W'(i2_q) + SUM_W'(i1n) - fb;
  assign i2n = sat(s2);

  assign wrap = (ramp_ctr_q == {RAMP_SHIFT{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q     <= '0;
      gain_q     <= '0;
      ramp_ctr_q <= '0;
      scaled_q   <= '0;
      filt_q     <= '0;
      i1_q       <= '0;
      i2_q       <= '0;
      q_q        <= 1'b0;
    end else begin
      if (sample_valid) held_q <= sample_in;
      ramp_ctr_q <= ramp_ctr_q + RAMP_SHIFT'(1);
      // mute is sampled only at wrap, so a toggle reverses the ramp in place
      if (wrap) begin
        if (!mute && gain_q < UNITY)       gain_q <= gain_q + GAIN_W'(1);
        else if (mute && gain_q != '0)     gain_q <= gain_q - GAIN_W'(1);
      end
      scaled_q <= scaled_d;
      filt_q   <= filt_d;
      i1_q     <= i1n;
      i2_q     <= i2n;
      q_q      <= ~i2n[INT_W-1];
    end
  end

  assign pwm_out   = q_q;
  assign ramp_done = mute ? (gain_q == '0) : (gain_q == UNITY);
endmodule

// File: tb/tb_audio_sd_dac.sv
// Directed bench for audio_sd_dac: soft start, DC duty sweep, smoothing,
// mute ramps with reversal and an asynchronous mid-stream reset.
module tb_audio_sd_dac;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       mute;
  logic       pwm0, done0, pwm4, done4;

  int checks = 0;
  int fails  = 0;

  audio_sd_dac #(.SMOOTH_SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .mute(mute), .pwm_out(pwm0), .ramp_done(done0));

  audio_sd_dac #(.SMOOTH_SHIFT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .mute(mute), .pwm_out(pwm4), .ramp_done(done4));

  always #5 clk = ~clk;

  typedef struct {
    int smp;
    int lo;
    int hi;
    bit satchk;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int s);
    sample_in    = 8'(s);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic sync_ctr();
    int n = 0;
    while (dut0.ramp_ctr_q != 6'd0 && n < 70) begin
      tick();
      n++;
    end
    chk("ramp_ctr_sync", n, 0, 64);
  endtask

  initial begin
    int ones, satn, fmax, xmin, xmax, g, gprev, bad;

    // 128*16 = 2048 ones in 4096 clocks; tolerance 16 ones
    tbl[0] = '{0,   -16,  16,   1'b0};
    tbl[1] = '{1,   0,    32,   1'b0};
    tbl[2] = '{16,  240,  272,  1'b0};
    tbl[3] = '{64,  1008, 1040, 1'b1};
    tbl[4] = '{128, 2032, 2064, 1'b1};
    tbl[5] = '{192, 3056, 3088, 1'b1};
    tbl[6] = '{255, 4064, 4096, 1'b0};

    rst_n = 1'b0; sample_in = 8'd0; sample_valid = 1'b0; mute = 1'b1;
    #2;
    chk("rst_ramp_done_muted", int'(done0), 1, 1);
    chk("rst_pwm", int'(pwm0), 0, 0);
    mute = 1'b0;
    #1;
    chk("rst_ramp_done_unmuted", int'(done0), 0, 0);
    repeat (3) tick();
    chk("rst_pwm_clocked", int'(pwm0), 0, 0);
    chk("rst_gain", int'(dut0.gain_q), 0, 0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 16384; n++) begin
      tick();
      if (n == 63)    chk("start_gain_63", int'(dut0.gain_q), 0, 0);
      if (n == 64)    chk("start_gain_64", int'(dut0.gain_q), 1, 1);
      if (n == 16383) chk("start_done_16383", int'(done0), 0, 0);
      if (n == 16384) chk("start_done_16384", int'(done0), 1, 1);
    end
    chk("start_gain_final", int'(dut0.gain_q), 256, 256);

    foreach (tbl[k]) begin
      strobe(tbl[k].smp);
      repeat (255) tick();
      ones = 0; satn = 0;
      repeat (4096) begin
        tick();
        ones += int'(pwm0);
        if (int'(dut0.i1_q) >= 2047 || int'(dut0.i1_q) <= -2048 ||
            int'(dut0.i2_q) >= 2047 || int'(dut0.i2_q) <= -2048) satn++;
      end
      chk($sformatf("duty_s%0d", tbl[k].smp), ones, tbl[k].lo, tbl[k].hi);
      if (tbl[k].satchk) chk($sformatf("nosat_s%0d", tbl[k].smp), satn, 0, 0);
    end

    // alternating full-scale samples every cycle through the smoothing filter
    ones = 0; fmax = 0; xmin = 255; xmax = 0;
    for (int c = 0; c < 256 + 4096; c++) begin
      sample_in    = (c % 2 == 0) ? 8'd255 : 8'd0;
      sample_valid = 1'b1;
      tick();
      if (c >= 256) begin
        ones += int'(pwm4);
        if (int'(dut4.filt_q) > fmax)        fmax = int'(dut4.filt_q);
        if (int'(dut4.filt_q >> 4) < xmin)   xmin = int'(dut4.filt_q >> 4);
        if (int'(dut4.filt_q >> 4) > xmax)   xmax = int'(dut4.filt_q >> 4);
      end
    end
    sample_valid = 1'b0;
    chk("alt_duty", ones, 2007, 2089);
    chk("alt_filt_max", fmax, 0, 4080);
    chk("alt_x_min", xmin, 112, 144);
    chk("alt_x_max", xmax, 112, 144);

    // mute at unity, reverse after 8000 clocks, ramp back up
    strobe(128);
    sync_ctr();
    mute = 1'b1;
    repeat (8000) tick();
    chk("rev_gain_at_8000", int'(dut0.gain_q), 130, 132);
    mute = 1'b0;
    gprev = int'(dut0.gain_q); bad = 0;
    for (int n = 1; n <= 8000; n++) begin
      tick();
      g = int'(dut0.gain_q);
      if (g != gprev && g != gprev + 1) bad++;
      gprev = g;
      if (n == 64)   chk("rev_first_step", g, 132, 132);
      if (n == 7999) chk("rev_done_7999", int'(done0), 0, 0);
      if (n == 8000) chk("rev_done_8000", int'(done0), 1, 1);
    end
    chk("rev_monotonic", bad, 0, 0);

    // full mute ramp, ramp_ctr is back at 0 here
    mute = 1'b1;
    for (int n = 1; n <= 16384; n++) begin
      tick();
      if (n == 16383) chk("mute_done_16383", int'(done0), 0, 0);
      if (n == 16384) chk("mute_done_16384", int'(done0), 1, 1);
    end
    chk("mute_gain_final", int'(dut0.gain_q), 0, 0);

    mute = 1'b0;
    repeat (1000) tick();
    chk("pre_rst_gain_nonzero", int'(dut0.gain_q), 1, 256);
    chk("pre_rst_held", int'(dut0.held_q), 128, 128);

    // asynchronous reset pulse between edges
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pwm", int'(pwm0), 0, 0);
    chk("arst_done", int'(done0), 0, 0);
    chk("arst_gain", int'(dut0.gain_q), 0, 0);
    chk("arst_held", int'(dut0.held_q), 0, 0);
    chk("arst_filt", int'(dut0.filt_q), 0, 0);
    chk("arst_i1", int'(dut0.i1_q), 0, 0);
    chk("arst_i2", int'(dut0.i2_q), 0, 0);
    chk("arst_ctr", int'(dut0.ramp_ctr_q), 0, 0);
    chk("arst_filt4", int'(dut4.filt_q), 0, 0);
    #9 rst_n = 1'b1;
    for (int n = 1; n <= 64; n++) begin
      tick();
      if (n == 63) chk("restart_gain_63", int'(dut0.gain_q), 0, 0);
      if (n == 63) chk("restart_done_63", int'(done0), 0, 0);
      if (n == 64) chk("restart_gain_64", int'(dut0.gain_q), 1, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
